rf_writeback: RTL

RF_WRITEBACK -- requirements
Module: rf_writeback

---
 rtl/core_pkg.sv | 44 ++++
 rtl/rf_writeback_if.sv | 19 +
 rtl/wb_fifo.sv | 50 +++++
 rtl/rf_writeback.sv | 103 ++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared writeback types: load funct3 encodings, the buffered result entry,
// and the load-data formatter used before results enter the writeback FIFO.
package core_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  // RV32I load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  // Extract and extend the addressed byte/halfword; unknown codes pass the word
  function automatic logic [XLEN-1:0] format_load(input logic [2:0]      funct3,
                                                  input logic [1:0]      byte_off,
                                                  input logic [XLEN-1:0] rdata);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] res;
    case (byte_off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      res = {{24{b[7]}}, b};
      LBU:     res = {24'b0, b};
      LH:      res = {{16{h[15]}}, h};
      LHU:     res = {16'b0, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rf_writeback_if.sv
// Push/pop channel between the writeback arbiter (master) and the result
// FIFO (slave).
//   push/push_entry : enqueue request and payload (ignored while full)
//   pop             : dequeue the head this cycle (ignored while empty)
//   head            : current head entry
//   full/empty      : derived from registered occupancy
interface rf_writeback_if;
  import core_pkg::*;

  logic      push;
  wb_entry_t push_entry;
  logic      pop;
  wb_entry_t head;
  logic      full;
  logic      empty;

  modport master (output push, push_entry, pop, input head, full, empty);
  modport slave  (input push, push_entry, pop, output head, full, empty);
endinterface

// File: rtl/wb_fifo.sv
// Result buffer for the register-file writeback path.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   fifo_if    : slave side of the push/pop channel
// DEPTH must be a power of two so pointers wrap naturally.
module wb_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  rf_writeback_if.slave  fifo_if
);
  import core_pkg::*;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  // Full is occupancy-only: a same-cycle pop never frees room for a push
  assign fifo_if.full  = (count == CNT_W'(DEPTH));
  assign fifo_if.empty = (count == '0);
  assign fifo_if.head  = mem[rptr];

  assign push_ok = fifo_if.push && !fifo_if.full;
  assign pop_ok  = fifo_if.pop && !fifo_if.empty;

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= PTR_W'(wptr + 1'b1);
      if (pop_ok)  rptr <= PTR_W'(rptr + 1'b1);
      count <= CNT_W'(count + CNT_W'(push_ok) - CNT_W'(pop_ok));
    end
  end

  // Storage needs no reset: entries are only read once counted valid
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= fifo_if.push_entry;
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback stage: arbitrates ALU and load results (load has
// fixed priority), formats load data, buffers results in wb_fifo, drains one
// per cycle into registered RF write outputs, and keeps a pending-write
// scoreboard.
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   alu_valid_i/ready_o/rd/data   : ALU result channel
//   lsu_valid_i/ready_o/rd/rdata/funct3/byte_off : load result channel
//   iss_valid_i, iss_rd_i         : issue marks destination busy
//   busy_o                        : pending-write scoreboard (bit 0 always 0)
//   rf_we_o/rf_waddr_o/rf_wdata_o : registered register-file write port
module rf_writeback
  import core_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        alu_valid_i,
  output logic        alu_ready_o,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_rdata_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [1:0]  lsu_byte_off_i,
  input  logic        iss_valid_i,
  input  logic [4:0]  iss_rd_i,
  output logic [31:0] busy_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  rf_writeback_if fifo_if ();

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .fifo_if (fifo_if)
  );

  logic        lsu_acc;
  logic        alu_acc;
  logic        push;
  wb_entry_t   push_entry;
  logic [31:0] busy_next;

  // Handshake: load wins; ALU stalls whenever a load is offered
  assign lsu_ready_o = !fifo_if.full;
  assign alu_ready_o = !fifo_if.full && !lsu_valid_i;
  assign lsu_acc     = lsu_valid_i && lsu_ready_o;
  assign alu_acc     = alu_valid_i && alu_ready_o;

  // Select the accepted result; x0 writes are consumed but never buffered
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (lsu_acc) begin
      push            = (lsu_rd_i != '0);
      push_entry.rd   = lsu_rd_i;
      push_entry.data = format_load(lsu_funct3_i, lsu_byte_off_i, lsu_rdata_i);
    end else if (alu_acc) begin
      push            = (alu_rd_i != '0);
      push_entry.rd   = alu_rd_i;
      push_entry.data = alu_data_i;
    end
  end

  assign fifo_if.push       = push;
  assign fifo_if.push_entry = push_entry;
  assign fifo_if.pop        = !fifo_if.empty;

  // Drain the head every cycle it exists; address/data hold between writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= fifo_if.pop;
      if (fifo_if.pop) begin
        rf_waddr_o <= fifo_if.head.rd;
        rf_wdata_o <= fifo_if.head.data;
      end
    end
  end

  // Scoreboard: clear on the completing write, then set on issue (set wins)
  always_comb begin
    busy_next = busy_o;
    if (rf_we_o) busy_next[rf_waddr_o] = 1'b0;
    if (iss_valid_i && (iss_rd_i != '0)) busy_next[iss_rd_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_o <= '0;
    else         busy_o <= busy_next;
  end

endmodule
